// File: rtl/fmul_pipe_pkg.sv
// fmul_pipe_pkg: shared defaults and rounding-mode encoding for the floating-point multiplier
package fmul_pipe_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 18;
  localparam int BIAS_DEF  = 127;
  typedef enum logic [0:0] {RND_TRUNC = 1'b0, RND_RNE = 1'b1} round_e;
endpackage

// File: rtl/fmul_pipe_normround.sv
// fmul_pipe_normround: normalise, round, range-check and pack a raw mantissa product
module fmul_pipe_normround
  import fmul_pipe_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int ROUND = 1
) (
  input  logic                       i_sign,
  input  logic                       i_zero,
  input  logic [EXP_W+1:0]           i_exp,
  input  logic [2*MAN_W-1:0]         i_prod,
  output logic [EXP_W+MAN_W:0]       o_q,
  output logic                       o_uf,
  output logic                       o_of
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W;
  logic [PW-1:0]    w_n;
  logic [EW-1:0]    w_en;
  logic [EW-1:0]    w_er;
  logic [MAN_W:0]   w_mr;
  logic [MAN_W-1:0] w_m;
  logic             w_inc;
  always_comb begin
    w_n   = i_prod[PW-1] ? i_prod : i_prod << 1;
    w_en  = i_prod[PW-1] ? i_exp : i_exp - EW'(1);
    w_inc = (ROUND == int'(RND_RNE)) && w_n[MAN_W-1] && ((|w_n[MAN_W-2:0]) || w_n[MAN_W]);
    w_mr  = {1'b0, w_n[PW-1 -: MAN_W]} + {{MAN_W{1'b0}}, w_inc};
    // a carry out leaves the low bits zero, so shifting right yields 100..0
    w_m   = w_mr[MAN_W] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
    w_er  = w_en + {{(EW-1){1'b0}}, w_mr[MAN_W]};
    o_uf  = !i_zero && (w_er[EW-1] || w_er == '0);
    o_of  = !i_zero && !w_er[EW-1] && (|w_er[EW-2:EXP_W]);
    o_q   = (i_zero || o_uf) ? {i_sign, {(W-1){1'b0}}} :
            o_of ? {i_sign, {(W-1){1'b1}}} : {i_sign, w_er[EXP_W-1:0], w_m};
  end
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: valid/ready pipelined floating-point multiplier with tag passthrough
// and underflow/overflow flags; stage valids collapse bubbles under backpressure.
module fmul_pipe
  import fmul_pipe_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MAN_W  = MAN_W_DEF,
  parameter int BIAS   = BIAS_DEF,
  parameter int STAGES = 3,
  parameter int ROUND  = 1,
  parameter int TAG_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   output_q,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   underflow,
  output logic                   overflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W;
  logic [STAGES:1]   r_v;
  logic [STAGES:1]   w_ld;
  logic [STAGES:1]   w_vprev;
  logic              r_s1;
  logic              r_z1;
  logic [EXP_W-1:0]  r_ea;
  logic [EXP_W-1:0]  r_eb;
  logic [MAN_W-1:0]  r_ma;
  logic [MAN_W-1:0]  r_mb;
  logic [TAG_W-1:0]  r_t1;
  logic              r_sg [2:STAGES-1];
  logic              r_zr [2:STAGES-1];
  logic [EW-1:0]     r_e  [2:STAGES-1];
  logic [PW-1:0]     r_p  [2:STAGES-1];
  logic [TAG_W-1:0]  r_tg [2:STAGES-1];
  logic [W-1:0]      r_q;
  logic [TAG_W-1:0]  r_tag;
  logic              r_uf;
  logic              r_of;
  logic [W-1:0]      w_q;
  logic              w_uf;
  logic              w_of;
  // stage k can load when some stage at or after it is empty, or the consumer takes a result
  for (genvar k = 1; k <= STAGES; k++) begin : g_ld
    assign w_ld[k] = out_ready || !(&r_v[STAGES:k]);
  end
  assign w_vprev   = {r_v[STAGES-1:1], in_valid};
  assign in_ready  = w_ld[1];
  assign out_valid = r_v[STAGES];
  assign output_q  = r_q;
  assign out_tag   = r_tag;
  assign underflow = r_uf;
  assign overflow  = r_of;
  fmul_pipe_normround #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND(ROUND)) u_nr (
    .i_sign (r_sg[STAGES-1]),
    .i_zero (r_zr[STAGES-1]),
    .i_exp  (r_e[STAGES-1]),
    .i_prod (r_p[STAGES-1]),
    .o_q    (w_q),
    .o_uf   (w_uf),
    .o_of   (w_of)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_s1  <= 1'b0;
      r_z1  <= 1'b0;
      r_ea  <= '0;
      r_eb  <= '0;
      r_ma  <= '0;
      r_mb  <= '0;
      r_t1  <= '0;
      for (int k = 2; k < STAGES; k++) begin
        r_sg[k] <= 1'b0;
        r_zr[k] <= 1'b0;
        r_e[k]  <= '0;
        r_p[k]  <= '0;
        r_tg[k] <= '0;
      end
      r_q   <= '0;
      r_tag <= '0;
      r_uf  <= 1'b0;
      r_of  <= 1'b0;
    end else begin
      for (int k = 1; k <= STAGES; k++)
        if (w_ld[k]) r_v[k] <= w_vprev[k];
      if (w_ld[1] && in_valid) begin
        r_s1 <= input_a[W-1] ^ input_b[W-1];
        r_z1 <= (~|input_a[W-2 -: EXP_W]) | (~|input_b[W-2 -: EXP_W]);
        r_ea <= input_a[W-2 -: EXP_W];
        r_eb <= input_b[W-2 -: EXP_W];
        r_ma <= input_a[MAN_W-1:0];
        r_mb <= input_b[MAN_W-1:0];
        r_t1 <= in_tag;
      end
      if (w_ld[2] && r_v[1]) begin
        r_sg[2] <= r_s1;
        r_zr[2] <= r_z1;
        r_e[2]  <= EW'(r_ea) + EW'(r_eb) - EW'(BIAS);
        r_p[2]  <= PW'(r_ma) * PW'(r_mb);
        r_tg[2] <= r_t1;
      end
      for (int k = 3; k < STAGES; k++)
        if (w_ld[k] && r_v[k-1]) begin
          r_sg[k] <= r_sg[k-1];
          r_zr[k] <= r_zr[k-1];
          r_e[k]  <= r_e[k-1];
          r_p[k]  <= r_p[k-1];
          r_tg[k] <= r_tg[k-1];
        end
      if (w_ld[STAGES] && r_v[STAGES-1]) begin
        r_q   <= w_q;
        r_tag <= r_tg[STAGES-1];
        r_uf  <= w_uf;
        r_of  <= w_of;
      end
    end
  end
endmodule
